// File: rtl/banco_pkg.sv
// Shared constants and state encoding for the register-bank write arbiter.
package banco_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      OCIOSO   = 1'b0,
      LIMPANDO = 1'b1
   } estado_e;
endpackage

// File: rtl/arbitro_rr2.sv
// Two-requester round-robin grant; the pointer flips to the other side after each accepted transfer.
module arbitro_rr2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic v0_i,
   input  logic v1_i,
   input  logic advance_i,
   output logic g0_o,
   output logic g1_o
);
   logic ptr_q, ptr_d;

   // ptr_q=0 favours requester 0 under contention
   assign g0_o = v0_i & (~v1_i | ~ptr_q);
   assign g1_o = v1_i & (~v0_i |  ptr_q);

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = g0_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: rtl/arbitro_escrita_br.sv
// Shares the register bank write port between the ALU and load paths, with a clear sweep and bypass flags.
module arbitro_escrita_br
   import banco_pkg::*;
#(
   parameter int DATA_W   = banco_pkg::DATA_W,
   parameter int ADDR_W   = banco_pkg::ADDR_W,
   parameter int NUM_REGS = banco_pkg::NUM_REGS
) (
   input  logic              ae_in_clk,
   input  logic              ae_in_rst,
   input  logic              ae_in_v0,
   output logic              ae_out_rdy0,
   input  logic [ADDR_W-1:0] ae_in_rd0,
   input  logic [DATA_W-1:0] ae_in_d0,
   input  logic              ae_in_v1,
   output logic              ae_out_rdy1,
   input  logic [ADDR_W-1:0] ae_in_rd1,
   input  logic [DATA_W-1:0] ae_in_d1,
   input  logic              ae_in_clr,
   output logic              ae_out_busy,
   output logic              ae_out_w_en,
   output logic [ADDR_W-1:0] ae_out_rd,
   output logic [DATA_W-1:0] ae_out_data,
   input  logic [ADDR_W-1:0] ae_in_rs,
   input  logic [ADDR_W-1:0] ae_in_rt,
   output logic              ae_out_pend_rs,
   output logic              ae_out_pend_rt,
   output logic [DATA_W-1:0] ae_out_fwd
);
   localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(1);

   estado_e           state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              w_en_q, w_en_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              g0, g1, rdy0, rdy1, advance;

   arbitro_rr2 u_rr (
      .clk_i     (ae_in_clk),
      .rst_i     (ae_in_rst),
      .v0_i      (ae_in_v0),
      .v1_i      (ae_in_v1),
      .advance_i (advance),
      .g0_o      (g0),
      .g1_o      (g1)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_en_d  = 1'b0;
      rd_d    = rd_q;
      data_d  = data_q;
      rdy0    = 1'b0;
      rdy1    = 1'b0;
      case (state_q)
         OCIOSO: begin
            if (ae_in_clr) begin
               state_d = LIMPANDO;
            end else begin
               rdy0 = g0 & ~ae_in_rst;
               rdy1 = g1 & ~ae_in_rst;
               // r0 writes are accepted but never staged
               if (ae_in_v0 && rdy0 && ae_in_rd0 != ZERO_A) begin
                  w_en_d = 1'b1;
                  rd_d   = ae_in_rd0;
                  data_d = ae_in_d0;
               end else if (ae_in_v1 && rdy1 && ae_in_rd1 != ZERO_A) begin
                  w_en_d = 1'b1;
                  rd_d   = ae_in_rd1;
                  data_d = ae_in_d1;
               end
            end
         end
         LIMPANDO: begin
            w_en_d = 1'b1;
            rd_d   = cnt_q;
            data_d = '0;
            if (cnt_q == LAST_A) begin
               state_d = OCIOSO;
               cnt_d   = FIRST_A;
            end else begin
               cnt_d = cnt_q + FIRST_A;
            end
         end
         default: state_d = OCIOSO;
      endcase
   end

   assign advance = (ae_in_v0 & rdy0) | (ae_in_v1 & rdy1);

   always_ff @(posedge ae_in_clk) begin
      if (ae_in_rst) begin
         state_q <= OCIOSO;
         cnt_q   <= FIRST_A;
         w_en_q  <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_en_q  <= w_en_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign ae_out_rdy0    = rdy0;
   assign ae_out_rdy1    = rdy1;
   assign ae_out_busy    = (state_q == LIMPANDO);
   assign ae_out_w_en    = w_en_q;
   assign ae_out_rd      = rd_q;
   assign ae_out_data    = data_q;
   assign ae_out_fwd     = data_q;
   assign ae_out_pend_rs = w_en_q && (rd_q == ae_in_rs) && (ae_in_rs != ZERO_A);
   assign ae_out_pend_rt = w_en_q && (rd_q == ae_in_rt) && (ae_in_rt != ZERO_A);
endmodule

// File: tb/tb_arbitro_escrita_br.sv
// Bench for arbitro_escrita_br: vector table plus sweep/reset sequences, staged writes tracked in a queue.
module tb_arbitro_escrita_br;
   logic        clk = 1'b0;
   logic        rst, v0, v1, clr;
   logic        rdy0, rdy1, busy, w_en, pend_rs, pend_rt;
   logic [4:0]  rd0, rd1, rs, rt, rd_o;
   logic [31:0] d0, d1, data_o, fwd;

   always #5 clk = ~clk;

   arbitro_escrita_br dut (
      .ae_in_clk      (clk),
      .ae_in_rst      (rst),
      .ae_in_v0       (v0),
      .ae_out_rdy0    (rdy0),
      .ae_in_rd0      (rd0),
      .ae_in_d0       (d0),
      .ae_in_v1       (v1),
      .ae_out_rdy1    (rdy1),
      .ae_in_rd1      (rd1),
      .ae_in_d1       (d1),
      .ae_in_clr      (clr),
      .ae_out_busy    (busy),
      .ae_out_w_en    (w_en),
      .ae_out_rd      (rd_o),
      .ae_out_data    (data_o),
      .ae_in_rs       (rs),
      .ae_in_rt       (rt),
      .ae_out_pend_rs (pend_rs),
      .ae_out_pend_rt (pend_rt),
      .ae_out_fwd     (fwd)
   );

   typedef struct {
      logic        rst, v0, v1, clr;
      logic [4:0]  rd0, rd1, rs, rt;
      logic [31:0] d0, d1;
      logic        er0, er1, ebusy;
   } vec_t;

   typedef struct {
      logic        w_en;
      logic [4:0]  rd;
      logic [31:0] data;
   } stage_t;

   stage_t      sb[$];
   int          n_chk = 0, n_pass = 0;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;
   logic [4:0]  sw_k;
   vec_t        tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One cycle: drive, check combinational/staged outputs at the negedge, predict the next staging.
   task automatic step(input vec_t t);
      stage_t e, n;
      rst = t.rst; v0 = t.v0; rd0 = t.rd0; d0 = t.d0;
      v1 = t.v1; rd1 = t.rd1; d1 = t.d1; clr = t.clr; rs = t.rs; rt = t.rt;
      #4;
      chk("rdy0", 32'(rdy0), 32'(t.er0));
      chk("rdy1", 32'(rdy1), 32'(t.er1));
      chk("busy", 32'(busy), 32'(t.ebusy));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("w_en", 32'(w_en), 32'(e.w_en));
         chk("rd",   32'(rd_o), 32'(e.rd));
         chk("data", data_o, e.data);
         chk("fwd",  fwd, e.data);
         chk("pend_rs", 32'(pend_rs), 32'(e.w_en && e.rd == t.rs && t.rs != 5'd0));
         chk("pend_rt", 32'(pend_rt), 32'(e.w_en && e.rd == t.rt && t.rt != 5'd0));
      end
      if (t.rst) begin
         hold_rd = '0; hold_data = '0; sw_k = 5'd1;
         n = '{1'b0, 5'd0, 32'd0};
      end else if (t.ebusy) begin
         hold_rd = sw_k; hold_data = '0;
         n = '{1'b1, sw_k, 32'd0};
         sw_k = (sw_k == 5'd31) ? 5'd1 : sw_k + 5'd1;
      end else if (t.er0 && t.v0 && t.rd0 != 0) begin
         hold_rd = t.rd0; hold_data = t.d0;
         n = '{1'b1, t.rd0, t.d0};
      end else if (t.er1 && t.v1 && t.rd1 != 0) begin
         hold_rd = t.rd1; hold_data = t.d1;
         n = '{1'b1, t.rd1, t.d1};
      end else begin
         n = '{1'b0, hold_rd, hold_data};
      end
      sb.push_back(n);
      @(posedge clk); #1;
   endtask

   function automatic vec_t mk(input logic r, input logic a0, input logic [4:0] a_rd0, input logic [31:0] a_d0,
                               input logic a1, input logic [4:0] a_rd1, input logic [31:0] a_d1,
                               input logic c, input logic [4:0] a_rs, input logic [4:0] a_rt,
                               input logic e0, input logic e1, input logic eb);
      vec_t t;
      t.rst = r; t.v0 = a0; t.rd0 = a_rd0; t.d0 = a_d0; t.v1 = a1; t.rd1 = a_rd1; t.d1 = a_d1;
      t.clr = c; t.rs = a_rs; t.rt = a_rt; t.er0 = e0; t.er1 = e1; t.ebusy = eb;
      return t;
   endfunction

   initial begin
      rst = 1'b1; v0 = 0; v1 = 0; clr = 0; rd0 = 0; rd1 = 0; d0 = 0; d1 = 0; rs = 0; rt = 0;
      hold_rd = '0; hold_data = '0; sw_k = 5'd1;
      @(posedge clk); #1;

      //        rst v0 rd0   d0            v1 rd1   d1        clr rs    rt    r0 r1 bsy
      tbl[0]  = mk(1, 1, 5'd8, 32'hDEADBEEF, 0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 5'd8, 32'hDEADBEEF, 0, 5'd0, 32'h0,     0, 5'd8, 5'd0, 1, 0, 0);
      tbl[2]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd8, 5'd8, 0, 0, 0);
      tbl[3]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd8, 5'd0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 0, 0, 0);
      tbl[5]  = mk(0, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,    0, 5'd3, 5'd4, 1, 0, 0);
      tbl[6]  = mk(0, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,    0, 5'd3, 5'd4, 0, 1, 0);
      tbl[7]  = mk(0, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,    0, 5'd3, 5'd4, 1, 0, 0);
      tbl[8]  = mk(0, 1, 5'd3, 32'h33,       1, 5'd4, 32'h44,    0, 5'd3, 5'd4, 0, 1, 0);
      tbl[9]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd4, 5'd3, 0, 0, 0);
      tbl[10] = mk(0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,  0, 5'd0, 5'd4, 0, 1, 0);
      tbl[11] = mk(0, 1, 5'd7, 32'h77,       1, 5'd9, 32'h99,    0, 5'd0, 5'd4, 1, 0, 0);
      tbl[12] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd7, 5'd9, 0, 0, 0);
      tbl[13] = mk(0, 1, 5'd5, 32'h55,       0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 1, 0, 0);
      tbl[14] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd5, 5'd0, 0, 0, 0);
      tbl[15] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd0, 5'd0, 0, 0, 0);
      foreach (tbl[i]) step(tbl[i]);

      // Clear sweep with a simultaneous request; clr held part of the way is ignored.
      step(mk(0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 5'd10, 5'd0, 0, 0, 0));
      for (int k = 1; k <= 31; k++)
         step(mk(0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, (k <= 20), 5'd10, 5'd0, 0, 0, 1));
      step(mk(0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 5'd31, 5'd0, 1, 0, 0));
      step(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0, 0, 5'd6, 5'd0, 0, 0, 0));

      // Reset while the staged sweep address is 10.
      step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 0, 0, 0));
      for (int k = 1; k <= 10; k++)
         step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd10, 5'd0, 0, 0, 1));
      step(mk(1, 0, 5'd0, 32'h0, 1, 5'd2, 32'h22, 0, 5'd10, 5'd0, 0, 0, 1));
      step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 5'd0,  5'd0, 0, 0, 0));
      step(mk(0, 0, 5'd0, 32'h0, 1, 5'd2, 32'h22, 0, 5'd2,  5'd0, 0, 1, 0));
      step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 5'd2,  5'd2, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
